me_ctrl: RTL and testbench

ME_CTRL -- requirements
Module: me_ctrl

---
 rtl/me_ctrl.sv | 154 +++++++++++++++
 tb/tb_me_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_ctrl.sv
// Motion-estimation scan controller: walks macroblocks in raster order,
// sequences the SAD core and holds each result until downstream takes it.
module me_ctrl #(
    parameter int MB_COLS = 240,
    parameter int MB_ROWS = 135
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        core_rst_n,
    output logic        fetch_en,
    output logic [4:0]  row_idx,
    output logic [7:0]  mb_x,
    output logic [7:0]  mb_y,
    input  logic        core_sad_en,
    input  logic [13:0] core_sad_min,
    input  logic [3:0]  core_mvx,
    input  logic [3:0]  core_mvy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [13:0] res_sad,
    output logic [3:0]  res_mvx,
    output logic [3:0]  res_mvy,
    output logic [7:0]  res_mb_x,
    output logic [7:0]  res_mb_y,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [7:0] LAST_X = 8'(MB_COLS - 1);
    localparam logic [7:0] LAST_Y = 8'(MB_ROWS - 1);
    localparam logic [4:0] CNT_CAP = 5'd24;
    localparam logic [4:0] CNT_FETCH = 5'd16;

    state_t     state;
    state_t     state_n;
    logic [4:0] cnt;
    logic       cap;
    logic       last_mb;
    logic       xfer;

    assign cap     = (state == RUN) && (cnt == CNT_CAP);
    assign last_mb = (mb_x == LAST_X) && (mb_y == LAST_Y);
    assign xfer    = res_valid && res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_n    = state;
        busy       = 1'b1;
        core_rst_n = 1'b0;
        fetch_en   = 1'b0;
        row_idx    = 5'd0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = RUN;
            end
            RUN: begin
                core_rst_n = 1'b1;
                if (cnt < CNT_FETCH) begin
                    fetch_en = 1'b1;
                    row_idx  = cnt;
                end
                if (cnt == CNT_CAP)
                    state_n = last_mb ? FLUSH : HOLD;
            end
            HOLD: begin
                if (res_ready) state_n = RUN;
            end
            FLUSH: begin
                if (xfer) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Cycle counter: runs only while in RUN, parked at zero elsewhere
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 5'd0;
        else if (state == RUN && cnt != CNT_CAP)
            cnt <= cnt + 5'd1;
        else
            cnt <= 5'd0;
    end

    // Raster position: cleared on frame start, advanced at each non-final capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mb_x <= 8'd0;
            mb_y <= 8'd0;
        end else if (state == IDLE && start) begin
            mb_x <= 8'd0;
            mb_y <= 8'd0;
        end else if (cap && !last_mb) begin
            if (mb_x == LAST_X) begin
                mb_x <= 8'd0;
                mb_y <= mb_y + 8'd1;
            end else begin
                mb_x <= mb_x + 8'd1;
            end
        end
    end

    // Result register: capture wins over a same-edge transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sad   <= 14'h3FFF;
            res_mvx   <= 4'd0;
            res_mvy   <= 4'd0;
            res_mb_x  <= 8'd0;
            res_mb_y  <= 8'd0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_sad   <= core_sad_min;
            res_mvx   <= core_mvx;
            res_mvy   <= core_mvy;
            res_mb_x  <= mb_x;
            res_mb_y  <= mb_y;
        end else if (xfer) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky alignment error: core strobe must coincide with the capture cycle
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == RUN && (core_sad_en != (cnt == CNT_CAP)))
            err <= 1'b1;
    end

    // Frame-complete pulse on the final transfer out of FLUSH
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= (state == FLUSH) && xfer;
    end

endmodule

// File: tb/tb_me_ctrl.sv
// Randomized bench for me_ctrl on a 2x2 macroblock frame, with a
// behavioural SAD-core model and an in-order result scoreboard.
module tb_me_ctrl;

    localparam int COLS = 2;
    localparam int ROWS = 2;
    localparam int NMB  = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        core_rst_n;
    logic        fetch_en;
    logic [4:0]  row_idx;
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
    logic        core_sad_en = 1'b0;
    logic [13:0] core_sad_min = 14'd0;
    logic [3:0]  core_mvx = 4'd0;
    logic [3:0]  core_mvy = 4'd0;
    logic        res_valid;
    logic        res_ready;
    logic [13:0] res_sad;
    logic [3:0]  res_mvx;
    logic [3:0]  res_mvy;
    logic [7:0]  res_mb_x;
    logic [7:0]  res_mb_y;
    logic        err;

    me_ctrl #(.MB_COLS(COLS), .MB_ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .core_rst_n(core_rst_n), .fetch_en(fetch_en), .row_idx(row_idx),
        .mb_x(mb_x), .mb_y(mb_y), .core_sad_en(core_sad_en),
        .core_sad_min(core_sad_min), .core_mvx(core_mvx),
        .core_mvy(core_mvy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sad(res_sad), .res_mvx(res_mvx), .res_mvy(res_mvy),
        .res_mb_x(res_mb_x), .res_mb_y(res_mb_y), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int cc = -1;
    int sad_at = 24;
    int n_push = 0;
    int n_pop = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit err_exp = 1'b0;
    bit pend = 1'b0;
    logic [37:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SAD core model: counts its own cycles out of reset, strobes at sad_at,
    // and predicts each result from raster order of the frame
    initial begin
        forever begin
            @(negedge clk);
            if (core_rst_n) begin
                cc++;
                core_sad_min = 14'($urandom);
                core_mvx     = 4'($urandom);
                core_mvy     = 4'($urandom);
                core_sad_en  = (cc == sad_at);
                if (core_sad_en != (cc == 24)) err_exp = 1'b1;
                chk("fetch_en", 64'(fetch_en), 64'(cc < 16));
                chk("row_idx", 64'(row_idx), 64'((cc < 16) ? cc : 0));
                if (cc == 24) begin
                    expq.push_back({core_sad_min, core_mvx, core_mvy,
                                    8'(n_push % COLS), 8'(n_push / COLS)});
                    n_push++;
                end
            end else begin
                cc = -1;
                core_sad_en = 1'b0;
            end
        end
    end

    // Downstream monitor: scoreboard transfers and expect done once after the last
    initial begin
        logic [37:0] r;
        forever begin
            @(negedge clk);
            if (done || pend) chk("done", 64'(done), 64'(pend));
            pend = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (res_valid && res_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_xfer", 64'd1, 64'd0);
                end else begin
                    r = expq.pop_front();
                    chk("res", 64'({res_sad, res_mvx, res_mvy,
                                    res_mb_x, res_mb_y}), 64'(r));
                end
                n_pop++;
                if (n_pop == NMB) pend = 1'b1;
            end
        end
    end

    task automatic check_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_fetch_en", 64'(fetch_en), 64'd0);
        chk("rst_row_idx", 64'(row_idx), 64'd0);
        chk("rst_mb", 64'({mb_x, mb_y}), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_sad", 64'(res_sad), 64'h3FFF);
        chk("rst_res_mv", 64'({res_mvx, res_mvy}), 64'd0);
        chk("rst_res_mb", 64'({res_mb_x, res_mb_y}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    task automatic frame_start();
        n_push = 0;
        n_pop = 0;
        done_cnt = 0;
        expq.delete();
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;

        // Full frame with downstream always ready
        res_ready = 1'b1;
        frame_start();
        wait_done(500);
        chk("a_results", 64'(n_pop), 64'(NMB));
        chk("a_done_cnt", 64'(done_cnt), 64'd1);
        k = done_cyc - start_cyc;
        chk("a_latency", 64'(k >= NMB * 26 - 1 && k <= NMB * 26 + 1), 64'd1);
        chk("a_err", 64'(err), 64'd0);

        // Backpressure: result held for 40 cycles
        res_ready = 1'b0;
        frame_start();
        k = 0;
        while (!res_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b_first_valid", 64'(res_valid), 64'd1);
        repeat (40) begin
            @(posedge clk); #1;
            chk("b_hold_core_rst", 64'(core_rst_n), 64'd0);
            chk("b_hold_busy", 64'(busy), 64'd1);
            chk("b_hold_valid", 64'(res_valid), 64'd1);
            if (expq.size() != 0)
                chk("b_hold_res", 64'({res_sad, res_mvx, res_mvy,
                                       res_mb_x, res_mb_y}), 64'(expq[0]));
        end
        res_ready = 1'b1;
        wait_done(500);
        chk("b_results", 64'(n_pop), 64'(NMB));
        chk("b_err", 64'(err), 64'd0);

        // Misaligned core strobe, then a clean frame: err must stay set
        sad_at = 23;
        frame_start();
        wait_done(500);
        chk("c_err", 64'(err), 64'(err_exp));
        chk("c_err_set", 64'(err), 64'd1);
        sad_at = 24;
        frame_start();
        wait_done(500);
        chk("c_err_sticky", 64'(err), 64'd1);
        chk("c_results", 64'(n_pop), 64'(NMB));

        // Reset at cnt 10 of the second macroblock
        frame_start();
        k = 0;
        while (!(n_push == 1 && cc == 9) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("d_reached_mb1", 64'(n_push == 1 && cc == 9), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        expq.delete();
        err_exp = 1'b0;
        done_cnt = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("d_no_done", 64'(done_cnt), 64'd0);
        frame_start();
        wait_done(500);
        chk("d_restart_results", 64'(n_pop), 64'(NMB));

        // Stray start pulses mid-frame are ignored
        frame_start();
        repeat (3) begin
            repeat ($urandom_range(5, 30)) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(500);
        chk("e_results", 64'(n_pop), 64'(NMB));
        chk("e_done_cnt", 64'(done_cnt), 64'd1);

        // Random downstream backpressure
        frame_start();
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            res_ready = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        chk("f_done_seen", 64'(done_cnt), 64'd1);
        chk("f_results", 64'(n_pop), 64'(NMB));
        chk("f_err", 64'(err), 64'(err_exp));
        res_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
